rr_bus_arbiter: RTL and testbench
=================================

Name: rr_bus_arbiter

Overview:
- Round-robin arbiter that shares one bus, port or functional unit among NUM_REQ requesters.
- Drives the select input of the shared-bus mux4to1/mux8to1/mux16to1 and the select of the demux1to8/demux1to16 return path.
- Guarantees a one-hot or empty grant and a bounded hold time per owner.
- Optional turnaround cycle keeps tristated demux outputs from overlapping between owners.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- MAX_HOLD, 8, maximum consecutive cycles one owner keeps grant; legal range 1..255.
- TURNAROUND, 1, when 1 forces one idle cycle between owners; when 0 allows back-to-back grants.
- SEL_BITS (localparam), $clog2(NUM_REQ), width of sel.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  request per requester, level; held high for the whole transfer.
- grant  output  NUM_REQ  one-hot grant, registered; all zero when bus idle.
- sel  output  SEL_BITS  binary index of current owner, registered; feeds mux/demux sel.
- bus_busy  output  1  high exactly when grant != 0.
- timeout  output  1  one-cycle pulse when an owner is forcibly released at MAX_HOLD.

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs: grant=0, sel=0, bus_busy=0, timeout=0.
  - Internal state: state=IDLE, hold_cnt=0, priority pointer ptr=0.
  - Reset asserted mid-transfer clears grant immediately, not at the next edge.
- States: IDLE, BUSY, TURN.
- Arbitration function, evaluated on a clock edge:
  - Winner = first index i with req[i]=1, scanning circularly from ptr upward.
  - On a grant: ptr <= (winner+1) mod NUM_REQ; grant <= onehot(winner); sel <= winner; bus_busy <= 1; hold_cnt <= 1; state <= BUSY.
  - No req set: nothing changes.
- IDLE:
  - Arbitrate every edge.
  - Latency: req sampled high at edge N gives grant visible right after edge N.
  - req rising between edges is seen at the next edge.
- BUSY, owner o:
  - req[o]=1 and hold_cnt<MAX_HOLD: stay in BUSY; hold_cnt++.
  - req[o]=0: normal release. grant <= 0 at that edge; bus_busy <= 0.
    - TURNAROUND=1: state <= TURN.
    - TURNAROUND=0: arbitrate at the same edge. If a winner exists, grant moves directly to it and bus_busy stays 1; otherwise state <= IDLE.
  - req[o]=1 and hold_cnt==MAX_HOLD: forced release. Same actions as normal release, plus timeout <= 1 for exactly one cycle.
    - The released requester may keep req high; ptr is already past it, so it is served only after the other pending requesters, or immediately if it is the sole requester.
  - Requests from non-owners are ignored until release.
- TURN:
  - grant=0 for exactly one cycle.
  - Arbitrate at the edge leaving TURN: a winner is granted, otherwise state <= IDLE.
- Hold-time bound: grant is high for at most MAX_HOLD consecutive cycles per grant.
- sel holds its last value while grant=0 and must not glitch. Consumers qualify it with bus_busy.
- timeout is 0 on every cycle other than the one following a forced release.
- Invariants, checked by bench assertions:
  - grant is one-hot or zero.
  - bus_busy == |grant.
  - grant[sel]==1 whenever bus_busy==1.
  - grant[i]==1 only if req[i] was 1 at the granting edge.
- A req pulse that drops before it is granted leaves no trace; no request is queued.

Test Plan:
1. Reset then req=4'b0100 held 3 cycles, then dropped -> grant=4'b0100 and sel=2 one cycle after req rises; grant stays 3 cycles; grant=0 the edge after req drops; timeout stays 0.
2. req=4'b1111 continuously, MAX_HOLD=8, TURNAROUND=1 -> grant order 0001,0010,0100,1000,0001. Each owner holds 8 cycles, then a timeout pulse and a 1-cycle gap; period 9 cycles per owner.
3. Fairness: owner 1 releases (ptr=2), req=4'b1001 pending -> grant=4'b1000, sel=3. After it releases, grant=4'b0001, sel=0.
4. TURNAROUND=0: owner 0 drops req while req[1]=1 -> grant changes 0001 to 0010 on the same edge; bus_busy never drops.
5. Sole requester req=4'b0010 held 20 cycles, MAX_HOLD=8, TURNAROUND=1 -> grant 8 cycles, gap 1, grant 8, gap 1, grant for the remaining cycles until req drops; timeout pulses after each forced release.
6. Reset asserted asynchronously mid-BUSY (owner 2) -> grant, bus_busy and sel go to 0 without a clock edge. After reset deassert with req=4'b1111, first grant=4'b0001 (ptr back to 0).

Source files
------------

// File: rtl/rr_bus_arbiter_if.sv
// Shared-bus arbitration interface: requester-side request vector plus the
// arbiter's registered grant, mux/demux select, busy and timeout indications.
interface rr_bus_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned SEL_BITS = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]  req;
  logic [NUM_REQ-1:0]  grant;
  logic [SEL_BITS-1:0] sel;
  logic                bus_busy;
  logic                timeout;

  // Requester side: drives requests, observes grant state.
  modport master (
    output req,
    input  grant,
    input  sel,
    input  bus_busy,
    input  timeout
  );

  // Arbiter side: observes requests, drives grant state.
  modport slave (
    input  req,
    output grant,
    output sel,
    output bus_busy,
    output timeout
  );
endinterface

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter for a shared bus. One-hot registered grant with a
// bounded hold time per owner and an optional idle turnaround cycle between
// owners so tristated return-path drivers never overlap.
module rr_bus_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MAX_HOLD   = 8,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic             clk,
  input  logic             reset,
  rr_bus_arbiter_if.slave  bus
);

  localparam int unsigned SEL_BITS = $clog2(NUM_REQ);
  localparam int unsigned CNT_BITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [SEL_BITS-1:0] sel_q, sel_d;
  logic [SEL_BITS-1:0] ptr_q, ptr_d;
  logic [CNT_BITS-1:0] hold_q, hold_d;
  logic                busy_q, busy_d;
  logic                timeout_q, timeout_d;

  int unsigned         scan_idx_c;
  logic                win_valid_c;
  logic [SEL_BITS-1:0] win_idx_c;
  logic                owner_req_c;
  logic                arb_en_c;

  // Circular priority search: first requester at or above ptr wins.
  always_comb begin
    win_valid_c = 1'b0;
    win_idx_c   = '0;
    scan_idx_c  = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx_c = (32'(ptr_q) + k) % NUM_REQ;
      if (!win_valid_c && bus.req[SEL_BITS'(scan_idx_c)]) begin
        win_valid_c = 1'b1;
        win_idx_c   = SEL_BITS'(scan_idx_c);
      end
    end
  end

  assign owner_req_c = bus.req[sel_q];

  // Next-state and next-output logic; a grant overrides release defaults.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    arb_en_c  = 1'b0;

    case (state_q)
      IDLE: begin
        arb_en_c = 1'b1;
      end
      BUSY: begin
        if (owner_req_c && (hold_q < CNT_BITS'(MAX_HOLD))) begin
          hold_d = hold_q + CNT_BITS'(1);
        end else begin
          // Normal release or forced release at the hold limit.
          grant_d   = '0;
          busy_d    = 1'b0;
          hold_d    = '0;
          timeout_d = owner_req_c;
          if (TURNAROUND != 0) begin
            state_d = TURN;
          end else begin
            state_d  = IDLE;
            arb_en_c = 1'b1;
          end
        end
      end
      TURN: begin
        state_d  = IDLE;
        arb_en_c = 1'b1;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase

    if (arb_en_c && win_valid_c) begin
      state_d = BUSY;
      grant_d = NUM_REQ'(1) << win_idx_c;
      sel_d   = win_idx_c;
      ptr_d   = SEL_BITS'((32'(win_idx_c) + 32'd1) % NUM_REQ);
      hold_d  = CNT_BITS'(1);
      busy_d  = 1'b1;
    end
  end

  // State register; reset clears grant immediately without waiting for clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      sel_q     <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.sel      = sel_q;
  assign bus.bus_busy = busy_q;
  assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Bench for rr_bus_arbiter: two instances (turnaround on / off) share one
// request vector; directed tables, hand sequences and random traffic are
// compared against a transaction-level reference model.
module tb_rr_bus_arbiter;

  localparam int MAXH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0;

  int total = 0;
  int bad   = 0;

  rr_bus_arbiter_if #(.NUM_REQ(4)) ifa ();
  rr_bus_arbiter_if #(.NUM_REQ(4)) ifb ();

  assign ifa.req = req;
  assign ifb.req = req;

  rr_bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(MAXH), .TURNAROUND(1)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  rr_bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(MAXH), .TURNAROUND(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave));

  always #5 clk = ~clk;

  // Reference model state per instance (0: turnaround, 1: back-to-back).
  int owner [2];
  int held  [2];
  int rr    [2];
  int lsel  [2];
  bit gap   [2];
  bit tmo   [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      owner[d] = -1; held[d] = 0; rr[d] = 0; lsel[d] = 0; gap[d] = 0; tmo[d] = 0;
    end
  endfunction

  // One clock edge of the arbitration rules, acting on whole transactions.
  function automatic void model_step(input int d, input logic [3:0] r);
    bit arb;
    arb = 0;
    tmo[d] = 0;
    if (owner[d] >= 0) begin
      if (r[owner[d]] && held[d] < MAXH) begin
        held[d]++;
      end else begin
        tmo[d] = r[owner[d]];
        owner[d] = -1;
        if (d == 0) gap[d] = 1;
        else arb = 1;
      end
    end else if (gap[d]) begin
      gap[d] = 0;
      arb = 1;
    end else begin
      arb = 1;
    end
    if (arb) begin
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (rr[d] + k) % 4;
        if (owner[d] < 0 && r[i]) begin
          owner[d] = i; held[d] = 1; rr[d] = (i + 1) % 4; lsel[d] = i;
        end
      end
    end
  endfunction

  function automatic logic [7:0] model_out(input int d);
    logic [3:0] g;
    g = (owner[d] >= 0) ? 4'(1 << owner[d]) : 4'b0;
    return {g, 2'(lsel[d]), (owner[d] >= 0), tmo[d]};
  endfunction

  function automatic logic [7:0] dut_out(input int d);
    if (d == 0) return {ifa.grant, ifa.sel, ifa.bus_busy, ifa.timeout};
    return {ifb.grant, ifb.sel, ifb.bus_busy, ifb.timeout};
  endfunction

  // Advance one edge and compare both instances with the model.
  task automatic tick();
    @(posedge clk);
    model_step(0, req);
    model_step(1, req);
    #1;
    chk("model_a {grant,sel,busy,tmo}", 32'(dut_out(0)), 32'(model_out(0)));
    chk("model_b {grant,sel,busy,tmo}", 32'(dut_out(1)), 32'(model_out(1)));
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Structural invariants sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      chk("inv_onehot_a", 32'($onehot0(ifa.grant)), 32'd1);
      chk("inv_onehot_b", 32'($onehot0(ifb.grant)), 32'd1);
      chk("inv_busy_a", 32'(ifa.bus_busy), 32'(|ifa.grant));
      chk("inv_busy_b", 32'(ifb.bus_busy), 32'(|ifb.grant));
      if (ifa.bus_busy) chk("inv_sel_a", 32'(ifa.grant[ifa.sel]), 32'd1);
      if (ifb.bus_busy) chk("inv_sel_b", 32'(ifb.grant[ifb.sel]), 32'd1);
    end
  end

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       tmo;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic [3:0] g;
    int slot, pos;

    // Directed table for the turnaround instance: single transfer, then fairness.
    vecs[0]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[2]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[3]  = '{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[4]  = '{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[5]  = '{4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[6]  = '{4'b1011, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[7]  = '{4'b1001, 4'b0000, 2'd1, 1'b0, 1'b0};
    vecs[8]  = '{4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[9]  = '{4'b0001, 4'b0000, 2'd3, 1'b0, 1'b0};
    vecs[10] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[11] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[12] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_a outputs", 32'(dut_out(0)), 32'h0);
    chk("reset_b outputs", 32'(dut_out(1)), 32'h0);

    for (int i = 0; i < 13; i++) begin
      req = vecs[i].req;
      tick();
      chk($sformatf("vec%0d", i), 32'(dut_out(0)),
          32'({vecs[i].grant, vecs[i].sel, vecs[i].busy, vecs[i].tmo}));
    end

    // All four requesting: 8-cycle tenures, timeout pulse in each gap.
    do_reset();
    req = 4'b1111;
    for (int c = 1; c <= 40; c++) begin
      tick();
      slot = (c - 1) / 9;
      pos  = (c - 1) % 9;
      g = (pos < 8) ? 4'(1 << (slot % 4)) : 4'b0;
      chk($sformatf("allreq grant c%0d", c), 32'(ifa.grant), 32'(g));
      chk($sformatf("allreq tmo c%0d", c), 32'(ifa.timeout), 32'(pos == 8));
    end

    // Back-to-back handover without turnaround.
    do_reset();
    req = 4'b0011;
    tick();
    chk("b2b first grant", 32'(ifb.grant), 32'h1);
    req = 4'b0010;
    tick();
    chk("b2b handover grant", 32'(ifb.grant), 32'h2);
    chk("b2b busy held", 32'(ifb.bus_busy), 32'h1);
    chk("b2b sel", 32'(ifb.sel), 32'h1);

    // Sole requester held for 20 edges.
    do_reset();
    req = 4'b0010;
    for (int c = 1; c <= 20; c++) begin
      tick();
      pos = (c - 1) % 9;
      chk($sformatf("sole grant c%0d", c), 32'(ifa.grant), (pos < 8) ? 32'h2 : 32'h0);
      chk($sformatf("sole tmo c%0d", c), 32'(ifa.timeout), 32'(pos == 8));
      chk($sformatf("sole b grant c%0d", c), 32'(ifb.grant), 32'h2);
    end
    req = 4'b0000;
    tick();
    chk("sole release", 32'(ifa.grant), 32'h0);

    // Asynchronous reset mid-transfer.
    do_reset();
    req = 4'b0100;
    tick();
    tick();
    chk("pre-reset owner", 32'(ifa.grant), 32'h4);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("async rst grant", 32'(ifa.grant), 32'h0);
    chk("async rst busy", 32'(ifa.bus_busy), 32'h0);
    chk("async rst sel", 32'(ifa.sel), 32'h0);
    req = 4'b1111;
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("post-reset grant", 32'(ifa.grant), 32'h1);

    // Random traffic with mostly-held requests.
    do_reset();
    req = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
